mul8_seq_ctrl: RTL and testbench

- Sequencer that computes an unsigned 8x8 -> 16-bit product by time-sharing one external 4x4 -> 8-bit combinational array multiplier over four cycles.
- Issues nibble operand pairs to the multiplier, shifts and accumulates the partial products, and presents the result through a valid/ready handshake.
- Sits between a requesting datapath and the existing 4x4 multiplier instance, which is wired externally to mul_a/mul_b/mul_p.

---
 rtl/mul8_seq_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_mul8_seq_ctrl.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/mul8_seq_ctrl.sv
// Sequential 8x8 unsigned multiplier controller: time-shares an external 4x4 multiplier over PP0..PP3.
// Optional zero-nibble skipping is enabled by defining MUL8_SEQ_ZERO_SKIP_EN.
module mul8_seq_ctrl #(
    parameter bit HOLD_PRODUCT = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic        flush,
    output logic [3:0]  mul_a,
    output logic [3:0]  mul_b,
    input  logic [7:0]  mul_p,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] product,
    output logic        busy
);

    localparam int unsigned W_OP   = 8;
    localparam int unsigned W_NIB  = 4;
    localparam int unsigned W_PROD = 16;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PP0  = 3'd1,
        S_PP1  = 3'd2,
        S_PP2  = 3'd3,
        S_PP3  = 3'd4,
        S_DONE = 3'd5
    } state_t;

    state_t              r_state;
    logic [W_OP-1:0]     r_a;
    logic [W_OP-1:0]     r_b;
    logic [W_PROD-1:0]   r_acc;
    logic [W_PROD-1:0]   r_product;
    logic                r_out_valid;
    logic                r_in_ready;
    logic                r_busy;
    logic [W_NIB-1:0]    r_mul_a;
    logic [W_NIB-1:0]    r_mul_b;

    logic [W_PROD-1:0]   w_pp;
    logic [W_PROD-1:0]   w_sum;
    logic [3:0]          w_nz_in;
    logic [3:0]          w_nz_reg;
    logic                w_accept;
    state_t              w_next_in;
    state_t              w_next_pp;

    // First PP state at or after index k whose nibble pair is enabled, else DONE.
    function automatic state_t f_next(input logic [2:0] k, input logic [3:0] nz);
        state_t s;
        s = S_DONE;
        for (int i = 3; i >= 0; i--) begin
            if (3'(i) >= k && nz[i]) s = state_t'(3'(i) + 3'd1);
        end
        return s;
    endfunction

    function automatic logic [W_NIB-1:0] f_mul_a(input state_t s, input logic [W_OP-1:0] x);
        case (s)
            S_PP0, S_PP2: return x[3:0];
            S_PP1, S_PP3: return x[7:4];
            default:      return '0;
        endcase
    endfunction

    function automatic logic [W_NIB-1:0] f_mul_b(input state_t s, input logic [W_OP-1:0] y);
        case (s)
            S_PP0, S_PP1: return y[3:0];
            S_PP2, S_PP3: return y[7:4];
            default:      return '0;
        endcase
    endfunction

`ifdef MUL8_SEQ_ZERO_SKIP_EN
    // Bit i set when partial product i has no zero nibble and must be computed.
    function automatic logic [3:0] f_nz(input logic [W_OP-1:0] x, input logic [W_OP-1:0] y);
        logic [3:0] nz;
        nz[0] = (|x[3:0]) && (|y[3:0]);
        nz[1] = (|x[7:4]) && (|y[3:0]);
        nz[2] = (|x[3:0]) && (|y[7:4]);
        nz[3] = (|x[7:4]) && (|y[7:4]);
        return nz;
    endfunction

    assign w_nz_in  = f_nz(a, b);
    assign w_nz_reg = f_nz(r_a, r_b);
`else
    assign w_nz_in  = 4'hF;
    assign w_nz_reg = 4'hF;
`endif

    // Partial product zero-extended and aligned for the current PP state.
    always_comb begin
        w_pp = '0;
        case (r_state)
            S_PP0:        w_pp = W_PROD'(mul_p);
            S_PP1, S_PP2: w_pp = W_PROD'(mul_p) << 4;
            S_PP3:        w_pp = W_PROD'(mul_p) << 8;
            default:      w_pp = '0;
        endcase
    end

    assign w_sum     = r_acc + w_pp;
    assign w_accept  = in_valid && r_in_ready && !flush;
    assign w_next_in = f_next(3'd0, w_nz_in);
    assign w_next_pp = f_next(r_state, w_nz_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_a         <= '0;
            r_b         <= '0;
            r_acc       <= '0;
            r_product   <= '0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_busy      <= 1'b0;
            r_mul_a     <= '0;
            r_mul_b     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a        <= a;
                        r_b        <= b;
                        r_acc      <= '0;
                        r_state    <= w_next_in;
                        r_mul_a    <= f_mul_a(w_next_in, a);
                        r_mul_b    <= f_mul_b(w_next_in, b);
                        r_in_ready <= 1'b0;
                        r_busy     <= 1'b1;
                        if (w_next_in == S_DONE) begin
                            r_product   <= '0;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_PP0, S_PP1, S_PP2, S_PP3: begin
                    if (flush) begin
                        r_state    <= S_IDLE;
                        r_acc      <= '0;
                        r_mul_a    <= '0;
                        r_mul_b    <= '0;
                        r_in_ready <= 1'b1;
                        r_busy     <= 1'b0;
                    end else begin
                        r_acc   <= w_sum;
                        r_state <= w_next_pp;
                        r_mul_a <= f_mul_a(w_next_pp, r_a);
                        r_mul_b <= f_mul_b(w_next_pp, r_b);
                        if (w_next_pp == S_DONE) begin
                            r_product   <= w_sum;
                            r_out_valid <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (flush || out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                        r_acc       <= '0;
                        r_in_ready  <= 1'b1;
                        r_busy      <= 1'b0;
                        if (!flush && !HOLD_PRODUCT) r_product <= '0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_busy      <= 1'b0;
                    r_mul_a     <= '0;
                    r_mul_b     <= '0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign product   = r_product;
    assign busy      = r_busy;
    assign mul_a     = r_mul_a;
    assign mul_b     = r_mul_b;

endmodule

// File: tb/tb_mul8_seq_ctrl.sv
// Directed bench for mul8_seq_ctrl with a behavioural 4x4 multiplier on mul_a/mul_b/mul_p.
module tb_mul8_seq_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        flush;
    logic [3:0]  mul_a;
    logic [3:0]  mul_b;
    logic [7:0]  mul_p;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] product;
    logic        busy;

    int checks = 0;
    int errors = 0;

`ifdef MUL8_SEQ_ZERO_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    mul8_seq_ctrl #(.HOLD_PRODUCT(1'b1)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .flush     (flush),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_p     (mul_p),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy)
    );

    // External 4x4 array multiplier.
    assign mul_p = 8'(mul_a) * 8'(mul_b);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
        logic [31:0] seq;
        int          lat;
        int          lat_skip;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic [15:0] exp_p,
                          input logic [31:0] exp_seq, input int lat_n, input int lat_s);
        int          edges;
        int          exp_lat;
        logic [31:0] seq;
        exp_lat = SKIP ? lat_s : lat_n;
        @(negedge clk);
        check("in_ready_idle", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        a = va;
        b = vb;
        @(negedge clk);
        in_valid = 1'b0;
        edges = 1;
        seq = '0;
        while (!out_valid && edges < 20) begin
            if (edges <= 4) seq = {seq[23:0], mul_a, mul_b};
            @(negedge clk);
            edges++;
        end
        check("latency", 32'(edges), 32'(exp_lat));
        check("product", 32'(product), 32'(exp_p));
`ifndef MUL8_SEQ_ZERO_SKIP_EN
        check("mul_seq", seq, exp_seq);
`endif
        check("mul_zero_in_done", 32'({mul_a, mul_b}), 32'd0);
        check("in_ready_done", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("out_valid_after_hs", 32'(out_valid), 32'd0);
        check("in_ready_after_hs", 32'(in_ready), 32'd1);
        check("busy_after_hs", 32'(busy), 32'd0);
        check("product_hold", 32'(product), 32'(exp_p));
    endtask

    initial begin
        int wait_cnt;
        vecs[0] = '{8'hFF, 8'hFF, 16'hFE01, 32'hFFFFFFFF, 5, 5};
        vecs[1] = '{8'h3C, 8'hA5, 16'h26AC, 32'hC535CA3A, 5, 5};
        vecs[2] = '{8'h80, 8'h02, 16'h0100, 32'h02820080, 5, 2};
        vecs[3] = '{8'h7F, 8'h00, 16'h0000, 32'hF070F070, 5, 1};
        vecs[4] = '{8'h0F, 8'h0F, 16'h00E1, 32'hFF0FF000, 5, 2};
        vecs[5] = '{8'h12, 8'h34, 16'h03A8, 32'h24142313, 5, 5};
        vecs[6] = '{8'h02, 8'h03, 16'h0006, 32'h23032000, 5, 2};

        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; flush = 1'b0; out_ready = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_product", 32'(product), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_mul", 32'({mul_a, mul_b}), 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].p, vecs[i].seq, vecs[i].lat, vecs[i].lat_skip);
        end

        // flush wins over in_valid while idle
        @(negedge clk);
        in_valid = 1'b1; flush = 1'b1; a = 8'h05; b = 8'h05;
        @(negedge clk);
        in_valid = 1'b0; flush = 1'b0;
        check("idle_flush_in_ready", 32'(in_ready), 32'd1);
        check("idle_flush_busy", 32'(busy), 32'd0);

        // backpressure: hold result for 7 cycles
        @(negedge clk);
        in_valid = 1'b1; a = 8'h3C; b = 8'hA5;
        @(negedge clk);
        in_valid = 1'b0;
        wait_cnt = 0;
        while (!out_valid && wait_cnt < 20) begin
            @(negedge clk);
            wait_cnt++;
        end
        for (int i = 0; i < 7; i++) begin
            check("bp_product", 32'(product), 32'h26AC);
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check("bp_hs_in_ready", 32'(in_ready), 32'd1);
        check("bp_hs_out_valid", 32'(out_valid), 32'd0);

        // flush in PP2 keeps previous product
        @(negedge clk);
        in_valid = 1'b1; a = 8'h12; b = 8'h34;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("pp2_mul", 32'({mul_a, mul_b}), 32'h23);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_busy", 32'(busy), 32'd0);
        check("flush_in_ready", 32'(in_ready), 32'd1);
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_product", 32'(product), 32'h26AC);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("flush_no_result", 32'(out_valid), 32'd0);
        end
        run_op(8'h02, 8'h03, 16'h0006, 32'h23032000, 5, 2);

        // async reset during PP1
        @(negedge clk);
        in_valid = 1'b1; a = 8'hFF; b = 8'hFF;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("pp1_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_out_valid", 32'(out_valid), 32'd0);
        check("arst_product", 32'(product), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_mul", 32'({mul_a, mul_b}), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(8'h10, 8'h10, 16'h0100, 32'h00100111, 5, 2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
        $fatal(1);
    end

endmodule
